// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: sync byte, FSM state
// encoding and the word-index to byte-address mapping.
package instr_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CNT_HI = 3'd1,
      ST_CNT_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   // Instruction memory is byte addressed; one word per 4 bytes.
   function automatic logic [15:0] word_addr(input logic [15:0] idx);
      return idx << 2;
   endfunction

endpackage

// File: rtl/instr_loader_word_packer.sv
// Packs bytes MSB-first into 32-bit words and raises word_ready for exactly
// one cycle after the 4th byte of a word has been shifted in.
module instr_loader_word_packer (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [23:0] shift_reg;
   logic [1:0]  count_reg;
   logic [31:0] word_reg;
   logic        ready_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         count_reg <= '0;
         word_reg  <= '0;
         ready_reg <= 1'b0;
      end else if (clear) begin
         shift_reg <= '0;
         count_reg <= '0;
         ready_reg <= 1'b0;
      end else if (shift) begin
         shift_reg <= {shift_reg[15:0], data};
         count_reg <= count_reg + 2'd1;
         if (count_reg == 2'd3) begin
            word_reg  <= {shift_reg, data};
            ready_reg <= 1'b1;
         end else begin
            ready_reg <= 1'b0;
         end
      end else begin
         ready_reg <= 1'b0;
      end
   end

   assign word       = word_reg;
   assign word_ready = ready_reg;

endmodule

// File: rtl/instr_loader.sv
// Framed byte stream -> instruction memory writer. Holds the CPU in reset
// (cpu_hold) until a frame completes with a matching XOR checksum.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned TIMEOUT  = 50000,
   parameter bit          HOLD_RST = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded
);

   localparam int          TW      = $clog2(TIMEOUT + 1);
   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   state_t          state_reg, state_next;
   logic [15:0]     count_reg, count_next;
   logic [7:0]      xor_reg, xor_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic            cpu_hold_reg, cpu_hold_next;
   logic [15:0]     words_reg, words_next;

   logic            transfer;
   logic            counting;
   logic            timeout_hit;
   logic            pack_clear;
   logic            pack_shift;
   logic [31:0]     pack_word;
   logic            word_ready;
   logic [15:0]     count_full;

   instr_loader_word_packer u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (pack_clear),
      .shift      (pack_shift),
      .data       (byte_in),
      .word       (pack_word),
      .word_ready (word_ready)
   );

   // The write cycle is the only cycle in which a byte cannot be taken.
   assign byte_ready = ~word_ready;
   assign transfer   = byte_valid & byte_ready;
   assign counting   = (state_reg == ST_CNT_HI) || (state_reg == ST_CNT_LO) ||
                       (state_reg == ST_DATA)   || (state_reg == ST_CSUM);
   assign timeout_hit = counting && !transfer && (timer_reg == TW'(TIMEOUT - 1));
   assign count_full  = {count_reg[15:8], byte_in};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         count_reg    <= '0;
         xor_reg      <= '0;
         timer_reg    <= '0;
         cpu_hold_reg <= HOLD_RST;
         words_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         xor_reg      <= xor_next;
         timer_reg    <= timer_next;
         cpu_hold_reg <= cpu_hold_next;
         words_reg    <= words_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      xor_next      = xor_reg;
      cpu_hold_next = cpu_hold_reg;
      words_next    = word_ready ? words_reg + 16'd1 : words_reg;
      timer_next    = (transfer || !counting) ? '0 : timer_reg + TW'(1);
      pack_clear    = 1'b0;
      pack_shift    = 1'b0;

      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (transfer && byte_in == SYNC_BYTE) begin
               state_next    = ST_CNT_HI;
               cpu_hold_next = 1'b1;
               words_next    = '0;
               xor_next      = '0;
               pack_clear    = 1'b1;
            end
         end
         ST_CNT_HI: begin
            if (transfer) begin
               count_next = {byte_in, 8'h00};
               state_next = ST_CNT_LO;
            end
         end
         ST_CNT_LO: begin
            if (transfer) begin
               count_next = count_full;
               if (count_full > DEPTH_W)
                  state_next = ST_ERROR;
               else if (count_full == 16'd0)
                  state_next = ST_CSUM;
               else
                  state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (transfer) begin
               pack_shift = 1'b1;
               xor_next   = xor_reg ^ byte_in;
            end
            if (word_ready && (words_reg + 16'd1 == count_reg))
               state_next = ST_CSUM;
         end
         ST_CSUM: begin
            if (transfer) begin
               if (byte_in == xor_reg) begin
                  state_next    = ST_DONE;
                  cpu_hold_next = 1'b0;
               end else begin
                  state_next = ST_ERROR;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // A stalled sender aborts the frame regardless of where it stopped.
      if (timeout_hit)
         state_next = ST_ERROR;
   end

   assign mem_we       = word_ready;
   assign mem_wdata    = pack_word;
   assign mem_addr     = word_addr(words_reg);
   assign cpu_hold     = cpu_hold_reg;
   assign load_done    = (state_reg == ST_DONE);
   assign load_error   = (state_reg == ST_ERROR);
   assign words_loaded = words_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader with a frame-level
// reference model (parse frame -> expected writes and final status).
`timescale 1ns/1ps
module tb_instr_loader;

   localparam int DEPTH   = 32;
   localparam int TIMEOUT = 200;

   logic        clock;
   logic        reset;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;
   logic [15:0] words_loaded;

   instr_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HOLD_RST(1'b1)) dut (
      .clock        (clock),
      .reset        (reset),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  frame_q[$];
   logic [15:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] exp_word_q[$];
   bit          exp_done;
   bit          exp_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clock)
      if (mem_we === 1'b1) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end

   // Reference: skip to sync, read N, take 4N big-endian bytes, compare XOR.
   task automatic model_frame(input bit truncated);
      int          i;
      int          n;
      logic [7:0]  x;
      logic [31:0] w;
      i = 0;
      exp_word_q.delete();
      while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
      i++;
      n = int'({frame_q[i], frame_q[i+1]});
      i += 2;
      if (n > DEPTH) begin
         exp_err  = 1'b1;
         exp_done = 1'b0;
         return;
      end
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
         if (i + 4 > frame_q.size()) break;
         w = {frame_q[i], frame_q[i+1], frame_q[i+2], frame_q[i+3]};
         x = x ^ frame_q[i] ^ frame_q[i+1] ^ frame_q[i+2] ^ frame_q[i+3];
         exp_word_q.push_back(w);
         i += 4;
      end
      if (truncated) begin
         exp_err  = 1'b1;
         exp_done = 1'b0;
      end else begin
         exp_done = (frame_q[i] == x);
         exp_err  = !exp_done;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (byte_ready) begin
            @(posedge clock);
            return;
         end
      end
      check_eq("ready_wait", 32'(byte_ready), 32'd1);
   endtask

   task automatic run_frame(input bit truncated, input string name);
      int nw;
      wr_addr_q.delete();
      wr_data_q.delete();
      model_frame(truncated);
      foreach (frame_q[i]) send_byte(frame_q[i]);
      byte_valid = 1'b0;
      if (truncated) begin
         repeat (TIMEOUT - 5) @(negedge clock);
         check_eq({name, ".early_err"}, 32'(load_error), 32'd0);
         repeat (10) @(negedge clock);
      end else begin
         repeat (4) @(negedge clock);
      end
      nw = exp_word_q.size();
      check_eq({name, ".n_writes"}, 32'(wr_addr_q.size()), 32'(nw));
      for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
         check_eq($sformatf("%s.addr%0d", name, i), 32'(wr_addr_q[i]), 32'(i * 4));
         check_eq($sformatf("%s.data%0d", name, i), wr_data_q[i], exp_word_q[i]);
      end
      check_eq({name, ".done"}, 32'(load_done), 32'(exp_done));
      check_eq({name, ".error"}, 32'(load_error), 32'(exp_err));
      check_eq({name, ".hold"}, 32'(cpu_hold), 32'(!exp_done));
      check_eq({name, ".words"}, 32'(words_loaded), 32'(nw));
      $display("frame %s: bytes=%0d writes=%0d done=%0d error=%0d words_loaded=%0d",
               name, frame_q.size(), wr_addr_q.size(), load_done, load_error, words_loaded);
   endtask

   task automatic random_frame(input int n, input bit good_csum, input int garbage);
      logic [7:0] x;
      logic [7:0] b;
      frame_q.delete();
      for (int g = 0; g < garbage; g++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h00;
         frame_q.push_back(b);
      end
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'(n >> 8));
      frame_q.push_back(8'(n));
      x = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
         b = 8'($urandom_range(0, 255));
         x = x ^ b;
         frame_q.push_back(b);
      end
      frame_q.push_back(good_csum ? x : ~x);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      clock      = 1'b0;
      reset      = 1'b1;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("rst.hold",  32'(cpu_hold),     32'd1);
      check_eq("rst.ready", 32'(byte_ready),   32'd1);
      check_eq("rst.we",    32'(mem_we),       32'd0);
      check_eq("rst.addr",  32'(mem_addr),     32'd0);
      check_eq("rst.wdata", mem_wdata,         32'd0);
      check_eq("rst.done",  32'(load_done),    32'd0);
      check_eq("rst.err",   32'(load_error),   32'd0);
      check_eq("rst.words", 32'(words_loaded), 32'd0);

      frame_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                  8'h00, 8'h00, 8'h00, 8'h0C, 8'h28};
      run_frame(1'b0, "good2");

      frame_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                  8'h00, 8'h00, 8'h00, 8'h0C, 8'h29};
      run_frame(1'b0, "badcsum");

      frame_q = '{8'hA5, 8'h00, 8'h21};
      run_frame(1'b0, "toobig");

      frame_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
      run_frame(1'b1, "timeout");

      frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
      run_frame(1'b0, "empty");

      frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h01,
                  8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      run_frame(1'b0, "garbage");

      // Abort mid-DATA: three data bytes in, then reset.
      wr_addr_q.delete();
      frame_q = '{8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
      foreach (frame_q[i]) send_byte(frame_q[i]);
      byte_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_eq("midrst.hold",  32'(cpu_hold),     32'd1);
      check_eq("midrst.ready", 32'(byte_ready),   32'd1);
      check_eq("midrst.done",  32'(load_done),    32'd0);
      check_eq("midrst.err",   32'(load_error),   32'd0);
      check_eq("midrst.words", 32'(words_loaded), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("midrst.nowrite", 32'(wr_addr_q.size()), 32'd0);
      $display("frame midreset: aborted after 3 data bytes, writes=%0d", wr_addr_q.size());

      frame_q = '{8'hDD, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      run_frame(1'b0, "after_rst");

      random_frame(DEPTH, 1'b1, 2);
      run_frame(1'b0, "rand_full");
      for (int t = 0; t < 6; t++) begin
         random_frame($urandom_range(1, DEPTH), ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 3));
         run_frame(1'b0, $sformatf("rand%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
